// File: rtl/tank_fill_if.sv
// tank_fill_if: request/sensor inputs and valve/pump outputs of the tank fill scheduler
interface tank_fill_if #(parameter int N_TANKS = 4);
    localparam int W = $clog2(N_TANKS);
    logic [N_TANKS-1:0] req;
    logic [N_TANKS-1:0] upper;
    logic               erro;
    logic               clr_fault;
    logic [N_TANKS-1:0] Valve_E;
    logic               pump_on;
    logic [W-1:0]       active_idx;
    logic [N_TANKS-1:0] fault_tank;
    logic               busy;
    modport master (
        output req, upper, erro, clr_fault,
        input  Valve_E, pump_on, active_idx, fault_tank, busy
    );
    modport slave (
        input  req, upper, erro, clr_fault,
        output Valve_E, pump_on, active_idx, fault_tank, busy
    );
endinterface

// File: rtl/tank_fill_scheduler.sv
// tank_fill_scheduler: round-robin sharing of one supply pump among N_TANKS tanks
module tank_fill_scheduler #(
    parameter int N_TANKS      = 4,
    parameter int PRIME_CYCLES = 2,
    parameter int FILL_TIMEOUT = 32
) (
    input  logic         clock,
    input  logic         reset,
    tank_fill_if.slave   bus
);
    localparam int W  = $clog2(N_TANKS);
    localparam int CW = $clog2(FILL_TIMEOUT + PRIME_CYCLES);
    typedef enum logic [2:0] {IDLE, PRIME, FILL, CLOSE, HALT} state_t;
    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [W-1:0]       idx, idx_n, rr, rr_n, pick, j;
    logic [N_TANKS-1:0] fault, fault_n, elig;
    assign elig = bus.req & ~bus.upper & ~fault;
    // descending scan so the lowest offset from rr wins
    always_comb begin
        pick = '0;
        j    = '0;
        for (int i = N_TANKS - 1; i >= 0; i--) begin
            j = W'((int'(rr) + i) % N_TANKS);
            if (elig[j]) pick = j;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        rr_n    = rr;
        fault_n = fault;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (bus.erro) state_n = HALT;
                else if (|elig) begin
                    idx_n   = pick;
                    state_n = PRIME;
                end
            end
            PRIME: begin
                if (bus.erro) state_n = HALT;
                else if (cnt == CW'(PRIME_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = FILL;
                end
            end
            FILL: begin
                if (bus.erro) state_n = HALT;
                else if (bus.upper[idx]) state_n = CLOSE;
                else if (cnt == CW'(FILL_TIMEOUT - 1)) begin
                    fault_n[idx] = 1'b1;
                    state_n      = CLOSE;
                end
            end
            CLOSE: begin
                if (bus.erro) state_n = HALT;
                else begin
                    rr_n    = (idx == W'(N_TANKS - 1)) ? '0 : idx + 1'b1;
                    state_n = IDLE;
                end
            end
            HALT: state_n = bus.erro ? HALT : IDLE;
            default: state_n = IDLE;
        endcase
        if (bus.clr_fault) fault_n = '0;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            rr    <= '0;
            fault <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            rr    <= rr_n;
            fault <= fault_n;
        end
    end
    assign bus.pump_on    = (state == PRIME) || (state == FILL);
    assign bus.Valve_E    = (state == FILL) ? (N_TANKS'(1) << idx) : '0;
    assign bus.active_idx = idx;
    assign bus.fault_tank = fault;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_tank_fill_scheduler.sv
// tb_tank_fill_scheduler: randomized fills checked by a scoreboard of expected valve episodes
module tb_tank_fill_scheduler;
    localparam int N = 4, P = 2, FT = 32;
    typedef struct {int idx; int op; int cl; logic [N-1:0] flt;} exp_t;
    logic clock = 1'b0, reset = 1'b1, clk_en = 1'b1, mon_en = 1'b0;
    int cyc = 0, total = 0, bad = 0, m_rr = 0;
    logic [N-1:0] m_fault = '0, prev_v = '0;
    exp_t q[$];
    tank_fill_if #(.N_TANKS(N)) bus();
    tank_fill_scheduler #(.N_TANKS(N), .PRIME_CYCLES(P), .FILL_TIMEOUT(FT)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );
    initial forever begin
        #5;
        if (clk_en) clock = ~clock;
    end
    always @(posedge clock) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask
    task automatic to_edge(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask
    // round-robin rule: first eligible tank at or after rr, wrapping
    function automatic int arb(input int rr, input logic [N-1:0] e);
        for (int i = 0; i < N; i++) if (e[(rr + i) % N]) return (rr + i) % N;
        return -1;
    endfunction
    always @(negedge clock) begin
        if (mon_en) begin
            chk("valve_onehot", 32'($countones(bus.Valve_E) <= 1), 32'd1);
            chk("valve_needs_pump", 32'(bus.Valve_E == '0 || bus.pump_on), 32'd1);
            if (prev_v == '0 && bus.Valve_E != '0) begin
                if (q.size() == 0) chk("unexpected_open", 32'(bus.Valve_E), 32'd0);
                else begin
                    chk("open_cycle", cyc, q[0].op);
                    chk("open_valve", 32'(bus.Valve_E), 32'(1 << q[0].idx));
                    chk("open_idx", 32'(bus.active_idx), q[0].idx);
                end
            end
            if (prev_v != '0 && bus.Valve_E == '0 && q.size() != 0) begin
                chk("close_cycle", cyc, q[0].cl);
                chk("close_fault", 32'(bus.fault_tank), 32'(q[0].flt));
                void'(q.pop_front());
            end
            prev_v <= bus.Valve_E;
        end
    end
    // modes: 0 upper after random k, 2 erro mid-fill, 3 timeout, 4 timeout with clr_fault, 5 upper on timeout cycle
    task automatic txn(input logic [N-1:0] force_req, input int mode);
        logic [N-1:0] r, u, e, ef;
        int idx, c, f, k, eo, h, f2, fin;
        r = (force_req != '0) ? force_req : N'($urandom_range(1, (1 << N) - 1));
        u = (force_req != '0) ? '0 : N'($urandom & $urandom);
        e = r & ~u & ~m_fault;
        bus.req = r;
        bus.upper = u;
        c = cyc;
        if (e == '0) begin
            to_edge(c + 3);
            chk("no_grant_busy", 32'(bus.busy), 32'd0);
            chk("no_grant_pump", 32'(bus.pump_on), 32'd0);
            bus.req = '0;
            bus.upper = '0;
            return;
        end
        idx = arb(m_rr, e);
        f = c + 1 + P;
        to_edge(c + 1);
        chk("prime_pump", 32'(bus.pump_on), 32'd1);
        chk("prime_valve", 32'(bus.Valve_E), 32'd0);
        if (mode == 0 || mode == 5) begin
            k = (mode == 5) ? FT : $urandom_range(1, FT);
            q.push_back(exp_t'{idx, f, f + k, m_fault});
            to_edge(f + k - 1);
            bus.upper[idx] = 1'b1;
            fin = f + k;
        end else if (mode == 3 || mode == 4) begin
            ef = (mode == 4) ? '0 : (m_fault | N'(1 << idx));
            q.push_back(exp_t'{idx, f, f + FT, ef});
            to_edge(f + FT - 1);
            bus.clr_fault = (mode == 4);
            m_fault = ef;
            fin = f + FT;
        end else begin
            eo = $urandom_range(1, FT - 1);
            h = $urandom_range(1, 10);
            q.push_back(exp_t'{idx, f, f + eo, m_fault});
            to_edge(f + eo - 1);
            bus.erro = 1'b1;
            to_edge(f + eo);
            chk("halt_busy", 32'(bus.busy), 32'd1);
            chk("halt_pump", 32'(bus.pump_on), 32'd0);
            chk("halt_valve", 32'(bus.Valve_E), 32'd0);
            to_edge(f + eo - 1 + h);
            bus.erro = 1'b0;
            f2 = f + eo + h + 1 + P;
            k = $urandom_range(1, FT);
            q.push_back(exp_t'{idx, f2, f2 + k, m_fault});
            to_edge(f2 + k - 1);
            bus.upper[idx] = 1'b1;
            fin = f2 + k;
        end
        to_edge(fin);
        chk("close_pump", 32'(bus.pump_on), 32'd0);
        bus.clr_fault = 1'b0;
        bus.req = '0;
        bus.upper = '0;
        m_rr = (idx + 1) % N;
        to_edge(fin + 1);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_fault", 32'(bus.fault_tank), 32'(m_fault));
    endtask
    task automatic clr_pulse();
        bus.clr_fault = 1'b1;
        to_edge(cyc + 1);
        bus.clr_fault = 1'b0;
        m_fault = '0;
    endtask
    initial begin
        int modes[10] = '{0, 0, 0, 0, 2, 2, 3, 3, 4, 5};
        int f;
        bus.req = '0;
        bus.upper = '0;
        bus.erro = 1'b0;
        bus.clr_fault = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
        chk("rst_valve", 32'(bus.Valve_E), 32'd0);
        chk("rst_pump", 32'(bus.pump_on), 32'd0);
        chk("rst_idx", 32'(bus.active_idx), 32'd0);
        chk("rst_fault", 32'(bus.fault_tank), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        txn(4'b0001, 0);
        repeat (5) txn(4'b1111, 0);
        txn(4'b0100, 3);
        txn(4'b0110, 0);
        clr_pulse();
        txn(4'b0100, 0);
        txn(4'b0010, 2);
        txn(4'b1001, 5);
        txn(4'b0100, 4);
        repeat (60) begin
            if ($urandom_range(0, 4) == 0) clr_pulse();
            txn('0, modes[$urandom_range(0, 9)]);
        end
        clr_pulse();
        txn(4'b1000, 3);
        bus.req = 4'b0001;
        f = cyc + 1 + P;
        q.push_back(exp_t'{0, f, f + 5, '0});
        to_edge(f + 4);
        reset = 1'b1;
        clk_en = 1'b0;
        #30;
        chk("held_clk_fault", 32'(bus.fault_tank), 32'b1000);
        chk("held_clk_valve", 32'(bus.Valve_E), 32'b0001);
        clk_en = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst_valve", 32'(bus.Valve_E), 32'd0);
        chk("midrst_pump", 32'(bus.pump_on), 32'd0);
        chk("midrst_fault", 32'(bus.fault_tank), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_idx", 32'(bus.active_idx), 32'd0);
        bus.req = '0;
        reset = 1'b0;
        m_fault = '0;
        m_rr = 0;
        to_edge(cyc + 1);
        txn(4'b0011, 0);
        to_edge(cyc + 3);
        chk("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
